// File: rtl/simmem_wresp_slot_bank.sv
// Write-response slot bank: parks responses in free slots and releases them on request.
// Optional SIMMEM_WRESP_OUT_REG_EN adds a single-entry output register.
module simmem_wresp_slot_bank #(
    parameter int  TotalCapacity = 64,
    parameter int  IdWidth       = 4,
    parameter int  RespWidth     = 2,
    localparam int SlotAddrWidth = $clog2(TotalCapacity)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [IdWidth-1:0]       in_id_i,
    input  logic [RespWidth-1:0]     in_resp_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    output logic [SlotAddrWidth-1:0] local_identifier_o,
    input  logic [TotalCapacity-1:0] release_en_i,
    output logic [TotalCapacity-1:0] address_released_onehot_o,
    output logic [IdWidth-1:0]       out_id_o,
    output logic [RespWidth-1:0]     out_resp_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i
);

    typedef enum logic [1:0] {
        SLOT_FREE,
        SLOT_STORED,
        SLOT_RELEASABLE
    } slot_state_e;

    slot_state_e            r_state     [TotalCapacity];
    slot_state_e            w_state_nxt [TotalCapacity];
    logic [IdWidth-1:0]     r_id        [TotalCapacity];
    logic [RespWidth-1:0]   r_resp      [TotalCapacity];

    logic                     w_any_free;
    logic [SlotAddrWidth-1:0] w_free_idx;
    logic                     w_any_rel;
    logic [SlotAddrWidth-1:0] w_rel_idx;
    logic [SlotAddrWidth-1:0] w_sel_idx;
    logic                     w_pop;
    logic [TotalCapacity-1:0] w_alloc_oh;
    logic [TotalCapacity-1:0] w_free_oh;

    // Downward scan so the lowest matching index wins.
    always_comb begin
        w_any_free = 1'b0;
        w_free_idx = '0;
        w_any_rel  = 1'b0;
        w_rel_idx  = '0;
        for (int k = TotalCapacity - 1; k >= 0; k--) begin
            if (r_state[k] == SLOT_FREE) begin
                w_any_free = 1'b1;
                w_free_idx = SlotAddrWidth'(k);
            end
            if (r_state[k] == SLOT_RELEASABLE) begin
                w_any_rel = 1'b1;
                w_rel_idx = SlotAddrWidth'(k);
            end
        end
    end

    assign in_ready_o         = w_any_free;
    assign local_identifier_o = w_free_idx;

    assign w_alloc_oh = (in_valid_i && w_any_free) ?
                        (TotalCapacity'(1) << w_free_idx) : '0;
    assign w_free_oh  = w_pop ? (TotalCapacity'(1) << w_sel_idx) : '0;

    assign address_released_onehot_o = w_free_oh;

    always_comb begin
        for (int k = 0; k < TotalCapacity; k++) begin
            w_state_nxt[k] = r_state[k];
            unique case (r_state[k])
                SLOT_FREE:       if (w_alloc_oh[k])   w_state_nxt[k] = SLOT_STORED;
                SLOT_STORED:     if (release_en_i[k]) w_state_nxt[k] = SLOT_RELEASABLE;
                SLOT_RELEASABLE: if (w_free_oh[k])    w_state_nxt[k] = SLOT_FREE;
                default:                              w_state_nxt[k] = SLOT_FREE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < TotalCapacity; k++) r_state[k] <= SLOT_FREE;
        end else begin
            for (int k = 0; k < TotalCapacity; k++) r_state[k] <= w_state_nxt[k];
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < TotalCapacity; k++) begin
            if (w_alloc_oh[k]) begin
                r_id[k]   <= in_id_i;
                r_resp[k] <= in_resp_i;
            end
        end
    end

`ifdef SIMMEM_WRESP_OUT_REG_EN
    logic                 r_ovld;
    logic [IdWidth-1:0]   r_oid;
    logic [RespWidth-1:0] r_oresp;

    // The slot is freed when it moves into the register, not at the handshake.
    assign w_sel_idx = w_rel_idx;
    assign w_pop     = w_any_rel && (!r_ovld || out_ready_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ovld  <= 1'b0;
            r_oid   <= '0;
            r_oresp <= '0;
        end else if (w_pop) begin
            r_ovld  <= 1'b1;
            r_oid   <= r_id[w_sel_idx];
            r_oresp <= r_resp[w_sel_idx];
        end else if (out_ready_i) begin
            r_ovld  <= 1'b0;
        end
    end

    assign out_valid_o = r_ovld;
    assign out_id_o    = r_oid;
    assign out_resp_o  = r_oresp;
`else
    logic                     r_hold_vld;
    logic [SlotAddrWidth-1:0] r_hold_idx;

    // A stalled presentation pins its slot until the handshake.
    assign w_sel_idx = r_hold_vld ? r_hold_idx : w_rel_idx;
    assign w_pop     = w_any_rel && out_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hold_vld <= 1'b0;
            r_hold_idx <= '0;
        end else begin
            r_hold_vld <= w_any_rel && !out_ready_i;
            r_hold_idx <= w_sel_idx;
        end
    end

    assign out_valid_o = w_any_rel;
    assign out_id_o    = w_any_rel ? r_id[w_sel_idx] : '0;
    assign out_resp_o  = w_any_rel ? r_resp[w_sel_idx] : '0;
`endif

endmodule

// File: tb/tb_simmem_wresp_slot_bank.sv
// Directed testbench for simmem_wresp_slot_bank.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_simmem_wresp_slot_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_id;
    logic [1:0]  in_resp;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  lid;
    logic [63:0] rel_en;
    logic [63:0] onehot;
    logic [3:0]  out_id;
    logic [1:0]  out_resp;
    logic        out_valid;
    logic        out_ready;

    int n_chk  = 0;
    int n_fail = 0;

    simmem_wresp_slot_bank dut (
        .clk_i                     (clk),
        .rst_ni                    (rst_n),
        .in_id_i                   (in_id),
        .in_resp_i                 (in_resp),
        .in_valid_i                (in_valid),
        .in_ready_o                (in_ready),
        .local_identifier_o        (lid),
        .release_en_i              (rel_en),
        .address_released_onehot_o (onehot),
        .out_id_o                  (out_id),
        .out_resp_o                (out_resp),
        .out_valid_o               (out_valid),
        .out_ready_i               (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_id     = '0;
        in_resp   = '0;
        in_valid  = 1'b0;
        rel_en    = '0;
        out_ready = 1'b0;
        repeat (2) step();
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_lid", 64'(lid), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_onehot", onehot, 64'd0);
        chk("rst_out_id", 64'(out_id), 64'd0);
        chk("rst_out_resp", 64'(out_resp), 64'd0);
        step();
        rst_n = 1'b1;

        // single response: store id=5 resp=2 in slot 0
        step();
        in_valid = 1'b1; in_id = 4'd5; in_resp = 2'd2;
        #1;
        chk("single_lid", 64'(lid), 64'd0);
        chk("single_in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        rel_en[0] = 1'b1;
        #1;
        chk("single_no_early_valid", 64'(out_valid), 64'd0);
`ifdef SIMMEM_WRESP_OUT_REG_EN
        step();
        #1;
        chk("oreg_t1_valid", 64'(out_valid), 64'd0);
        chk("oreg_t1_onehot", onehot, 64'd1);
        step();
        rel_en = '0;
        #1;
        chk("oreg_t2_valid", 64'(out_valid), 64'd1);
        chk("oreg_t2_id", 64'(out_id), 64'd5);
        chk("oreg_t2_resp", 64'(out_resp), 64'd2);
        chk("oreg_t2_onehot", onehot, 64'd0);
        out_ready = 1'b1;
        #1;
        chk("oreg_hs_onehot", onehot, 64'd0);
        step();
        out_ready = 1'b0;
        #1;
        chk("oreg_drained", 64'(out_valid), 64'd0);
        chk("oreg_in_ready", 64'(in_ready), 64'd1);
`else
        step();
        #1;
        chk("single_valid_t1", 64'(out_valid), 64'd1);
        chk("single_id", 64'(out_id), 64'd5);
        chk("single_resp", 64'(out_resp), 64'd2);
        chk("single_onehot_stall", onehot, 64'd0);
        out_ready = 1'b1;
        #1;
        chk("single_onehot_hs", onehot, 64'd1);
        step();
        rel_en = '0;
        out_ready = 1'b0;
        #1;
        chk("single_onehot_gone", onehot, 64'd0);
        chk("single_empty", 64'(out_valid), 64'd0);

        // release enables on free slots, and during allocation, are ignored
        rel_en[5] = 1'b1;
        rel_en[0] = 1'b1;
        in_valid = 1'b1; in_id = 4'd1; in_resp = 2'd1;
        #1;
        chk("ign_alloc_lid", 64'(lid), 64'd0);
        step();
        in_valid = 1'b0;
        rel_en = '0;
        #1;
        chk("ign_free_and_alloc", 64'(out_valid), 64'd0);
        step();
        #1;
        chk("ign_still_stored", 64'(out_valid), 64'd0);
        chk("ign_lid_next", 64'(lid), 64'd1);
        rel_en[0] = 1'b1;
        step();
        rel_en = '0;
        out_ready = 1'b1;
        #1;
        chk("ign_late_release_id", 64'(out_id), 64'd1);
        chk("ign_late_release_oh", onehot, 64'd1);
        step();
        out_ready = 1'b0;
        #1;
        chk("ign_empty", 64'(out_valid), 64'd0);

        // fill all 64 slots, id = slot[3:0], resp = slot[1:0]
        for (int i = 0; i < 64; i++) begin
            in_valid = 1'b1;
            in_id    = 4'(i);
            in_resp  = 2'(i);
            #1;
            chk($sformatf("fill_lid_%0d", i), 64'(lid), 64'(i));
            step();
        end
        in_valid = 1'b0;
        #1;
        chk("fill_full", 64'(in_ready), 64'd0);

        // release 7, 3, 40 together; expect order 3, 7, 40
        rel_en[7] = 1'b1; rel_en[3] = 1'b1; rel_en[40] = 1'b1;
        step();
        rel_en = '0;
        #1;
        chk("ord_valid", 64'(out_valid), 64'd1);
        chk("ord_first_id", 64'(out_id), 64'd3);
        out_ready = 1'b1;
        #1;
        chk("ord_oh_3", onehot, 64'd1 << 3);
        step();
        #1;
        chk("ord_id_7", 64'(out_id), 64'd7);
        chk("ord_oh_7", onehot, 64'd1 << 7);
        step();
        #1;
        chk("ord_id_40", 64'(out_id), 64'd8);
        chk("ord_resp_40", 64'(out_resp), 64'd0);
        chk("ord_oh_40", onehot, 64'd1 << 40);
        step();
        out_ready = 1'b0;
        #1;
        chk("ord_empty", 64'(out_valid), 64'd0);
        chk("ord_lid_3", 64'(lid), 64'd3);
        in_valid = 1'b1; in_id = 4'd3; in_resp = 2'd3;
        step();
        in_valid = 1'b0;
        #1;
        chk("ord_lid_after", 64'(lid), 64'd7);

        // backpressure: slot 9 presented, slot 2 released mid-stall
        rel_en[9] = 1'b1;
        step();
        rel_en = '0;
        for (int c = 0; c < 10; c++) begin
            if (c == 4) rel_en[2] = 1'b1;
            if (c == 5) rel_en = '0;
            #1;
            chk($sformatf("bp_id_%0d", c), 64'(out_id), 64'd9);
            chk($sformatf("bp_oh_%0d", c), onehot, 64'd0);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_pop9", onehot, 64'd1 << 9);
        step();
        #1;
        chk("bp_id_2", 64'(out_id), 64'd2);
        chk("bp_pop2", onehot, 64'd1 << 2);
        step();
        out_ready = 1'b0;
        #1;
        chk("bp_empty", 64'(out_valid), 64'd0);

        // refill freed slots 2, 7, 9, 40
        in_valid = 1'b1; in_id = 4'd0; in_resp = 2'd0;
        #1; chk("refill_2", 64'(lid), 64'd2); step();
        #1; chk("refill_7", 64'(lid), 64'd7); step();
        #1; chk("refill_9", 64'(lid), 64'd9); step();
        #1; chk("refill_40", 64'(lid), 64'd40); step();
        in_valid = 1'b0;
        #1;
        chk("refill_full", 64'(in_ready), 64'd0);

        // full bank: pop slot 0 while in_valid is high
        rel_en[0] = 1'b1;
        step();
        rel_en = '0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_id = 4'hC; in_resp = 2'd1;
        #1;
        chk("sim_no_accept", 64'(in_ready), 64'd0);
        chk("sim_pop0", onehot, 64'd1);
        step();
        out_ready = 1'b0;
        #1;
        chk("sim_ready_next", 64'(in_ready), 64'd1);
        chk("sim_lid_0", 64'(lid), 64'd0);
        step();
        in_valid = 1'b0;
        #1;
        chk("sim_full_again", 64'(in_ready), 64'd0);
        rel_en[0] = 1'b1;
        step();
        rel_en = '0;
        #1;
        chk("sim_new_id", 64'(out_id), 64'hC);
        chk("sim_new_resp", 64'(out_resp), 64'd1);

        // reset mid-operation with a full bank and a releasable slot
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 64'(out_valid), 64'd0);
        chk("mrst_ready", 64'(in_ready), 64'd1);
        chk("mrst_lid", 64'(lid), 64'd0);
        chk("mrst_onehot", onehot, 64'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) begin
            in_valid = 1'b1;
            #1;
            chk($sformatf("mrst_free_%0d", i), 64'(in_ready), 64'd1);
            step();
        end
        in_valid = 1'b0;
        #1;
        chk("mrst_full", 64'(in_ready), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
